fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 139 +++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time, feeding a
// 2-entry {pc, instr} buffer, with redirect flush and stale-response dropping.
module fetch_unit #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        PCSrc,
   input  logic [31:0] Result,
   output logic        IMemReq,
   output logic [31:0] IMemAddr,
   input  logic        IMemGnt,
   input  logic        IMemValid,
   input  logic [31:0] IMemRData,
   output logic [31:0] Instr,
   output logic        InstrValid,
   input  logic        InstrReady,
   output logic [31:0] PC,
   output logic [31:0] PCPlus8
);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t      state_q, state_d;
   logic [31:0] fpc_q, fpc_d;
   logic [31:0] tag_q, tag_d;
   logic [1:0]  count_q, count_d;
   logic        rd_ptr_q, rd_ptr_d;
   logic        wr_ptr_q, wr_ptr_d;
   logic [31:0] pc_mem_q [2];
   logic [31:0] pc_mem_d [2];
   logic [31:0] instr_mem_q [2];
   logic [31:0] instr_mem_d [2];

   logic        grant;
   logic        push;
   logic        pop;
   logic        head_valid;
   logic [31:0] head_pc;
   logic [31:0] head_instr;
   logic        unused_result_bits;

   assign unused_result_bits = ^Result[1:0];

   // The count<2 gate reserves a buffer slot for the single in-flight word.
   assign IMemReq    = (state_q == IDLE) && (count_q != 2'd2) && !PCSrc && !RESET;
   assign IMemAddr   = RESET ? 32'h0 : {fpc_q[31:2], 2'b00};
   assign grant      = IMemReq && IMemGnt;
   assign push       = (state_q == WAIT) && IMemValid;
   assign head_valid = (count_q != 2'd0);
   assign pop        = head_valid && InstrReady;
   assign head_pc    = pc_mem_q[rd_ptr_q];
   assign head_instr = instr_mem_q[rd_ptr_q];

   assign InstrValid = head_valid && !RESET;
   assign Instr      = RESET ? 32'h0 : head_instr;
   assign PC         = RESET ? 32'h0 : head_pc;
   assign PCPlus8    = RESET ? 32'h0 : head_pc + 32'd8;

   always_comb begin
      state_d     = state_q;
      fpc_d       = fpc_q;
      tag_d       = tag_q;
      count_d     = count_q;
      rd_ptr_d    = rd_ptr_q;
      wr_ptr_d    = wr_ptr_q;
      pc_mem_d    = pc_mem_q;
      instr_mem_d = instr_mem_q;

      if (PCSrc) begin
         // Redirect wins over everything; a live request becomes stale.
         fpc_d    = {Result[31:2], 2'b00};
         count_d  = 2'd0;
         rd_ptr_d = 1'b0;
         wr_ptr_d = 1'b0;
         if (state_q == WAIT) begin
            state_d = IMemValid ? IDLE : DROP;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (grant) begin
                  tag_d   = fpc_q;
                  fpc_d   = fpc_q + 32'd4;
                  state_d = WAIT;
               end
            end
            WAIT: begin
               if (IMemValid) state_d = IDLE;
            end
            DROP: begin
               if (IMemValid) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase

         if (push) begin
            pc_mem_d[wr_ptr_q]    = tag_q;
            instr_mem_d[wr_ptr_q] = IMemRData;
            wr_ptr_d              = ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q  <= IDLE;
         fpc_q    <= {RESET_VECTOR[31:2], 2'b00};
         count_q  <= 2'd0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         fpc_q    <= fpc_d;
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
      end
      tag_q       <= tag_d;
      pc_mem_q    <= pc_mem_d;
      instr_mem_q <= instr_mem_d;
   end

   always_ff @(posedge CLK) begin
      if (!RESET && !PCSrc) begin
         assert (!(push && (count_q == 2'd2)))
            else $error("fetch_unit: push into full instruction buffer");
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory handshake is driven by hand, cycle by
// cycle, and outputs are checked against hand-computed values.
module tb_fetch_unit;

   logic        CLK;
   logic        RESET;
   logic        PCSrc;
   logic [31:0] Result;
   logic        IMemReq;
   logic [31:0] IMemAddr;
   logic        IMemGnt;
   logic        IMemValid;
   logic [31:0] IMemRData;
   logic [31:0] Instr;
   logic        InstrValid;
   logic        InstrReady;
   logic [31:0] PC;
   logic [31:0] PCPlus8;

   int checks;
   int failures;

   fetch_unit #(.RESET_VECTOR(32'h0000_0000)) dut (
      .CLK(CLK), .RESET(RESET), .PCSrc(PCSrc), .Result(Result),
      .IMemReq(IMemReq), .IMemAddr(IMemAddr), .IMemGnt(IMemGnt),
      .IMemValid(IMemValid), .IMemRData(IMemRData), .Instr(Instr),
      .InstrValid(InstrValid), .InstrReady(InstrReady), .PC(PC),
      .PCPlus8(PCPlus8)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
         else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   initial begin
      checks = 0;
      failures = 0;
      RESET = 1'b1; PCSrc = 1'b0; Result = 32'h0; IMemGnt = 1'b0;
      IMemValid = 1'b0; IMemRData = 32'h0; InstrReady = 1'b0;
      tick(); tick();

      // Reset outputs, with a redirect attempt that reset must override
      PCSrc = 1'b1; Result = 32'h0000_0200; IMemGnt = 1'b1;
      settle();
      chk("rst_req",    {31'h0, IMemReq}, 32'h0);
      chk("rst_ivalid", {31'h0, InstrValid}, 32'h0);
      chk("rst_addr",   IMemAddr, 32'h0);
      chk("rst_pc",     PC, 32'h0);
      chk("rst_pc8",    PCPlus8, 32'h0);
      chk("rst_instr",  Instr, 32'h0);
      tick();
      RESET = 1'b0; PCSrc = 1'b0; Result = 32'h0; IMemGnt = 1'b1;
      settle();
      chk("a_req",  {31'h0, IMemReq}, 32'h1);
      chk("a_addr", IMemAddr, 32'h0);
      chk("a_ivalid", {31'h0, InstrValid}, 32'h0);
      tick();

      // WAIT: first word returns
      chk("b_req_wait", {31'h0, IMemReq}, 32'h0);
      IMemValid = 1'b1; IMemRData = 32'hE3A0_0001;
      tick();
      IMemValid = 1'b0;
      settle();
      chk("c_ivalid", {31'h0, InstrValid}, 32'h1);
      chk("c_pc",     PC, 32'h0);
      chk("c_pc8",    PCPlus8, 32'h8);
      chk("c_instr",  Instr, 32'hE3A0_0001);
      chk("c_req",    {31'h0, IMemReq}, 32'h1);
      chk("c_addr",   IMemAddr, 32'h4);
      tick();
      IMemValid = 1'b1; IMemRData = 32'hE280_0002;
      tick();
      IMemValid = 1'b0;
      settle();

      // Buffer full: no request, head stable
      chk("e_req_full", {31'h0, IMemReq}, 32'h0);
      chk("e_pc",       PC, 32'h0);
      tick();
      chk("f_req_full", {31'h0, IMemReq}, 32'h0);
      chk("f_instr",    Instr, 32'hE3A0_0001);
      InstrReady = 1'b1;
      tick();
      InstrReady = 1'b0;
      settle();
      chk("g_pc",     PC, 32'h4);
      chk("g_instr",  Instr, 32'hE280_0002);
      chk("g_req",    {31'h0, IMemReq}, 32'h1);
      chk("g_addr",   IMemAddr, 32'h8);
      IMemGnt = 1'b1;
      tick();

      // Redirect during WAIT, stale response two cycles later
      PCSrc = 1'b1; Result = 32'h0000_0100; IMemGnt = 1'b0;
      settle();
      chk("h_req_pcsrc", {31'h0, IMemReq}, 32'h0);
      tick();
      PCSrc = 1'b0;
      settle();
      chk("i_ivalid", {31'h0, InstrValid}, 32'h0);
      chk("i_req_drop", {31'h0, IMemReq}, 32'h0);
      tick();
      IMemValid = 1'b1; IMemRData = 32'hDEAD_BEEF;
      settle();
      chk("j_req_drop", {31'h0, IMemReq}, 32'h0);
      tick();
      IMemValid = 1'b0;
      settle();
      chk("k_ivalid", {31'h0, InstrValid}, 32'h0);
      chk("k_req",    {31'h0, IMemReq}, 32'h1);
      chk("k_addr",   IMemAddr, 32'h100);
      IMemGnt = 1'b1;
      tick();
      IMemGnt = 1'b0; IMemValid = 1'b1; IMemRData = 32'h1111_1111;
      tick();
      IMemValid = 1'b0;
      settle();
      chk("m_pc",    PC, 32'h100);
      chk("m_instr", Instr, 32'h1111_1111);
      IMemGnt = 1'b1;
      tick();

      // Redirect coinciding with response and pop; low bits of target ignored
      IMemGnt = 1'b0; PCSrc = 1'b1; Result = 32'h0000_0043;
      IMemValid = 1'b1; IMemRData = 32'h2222_2222; InstrReady = 1'b1;
      tick();
      PCSrc = 1'b0; IMemValid = 1'b0; InstrReady = 1'b0;
      settle();
      chk("o_ivalid", {31'h0, InstrValid}, 32'h0);
      chk("o_req",    {31'h0, IMemReq}, 32'h1);
      chk("o_addr",   IMemAddr, 32'h40);

      // Redirect beats grant; fetch at top of address space wraps
      PCSrc = 1'b1; Result = 32'hFFFF_FFFF; IMemGnt = 1'b1;
      tick();
      PCSrc = 1'b0;
      settle();
      chk("p_req",  {31'h0, IMemReq}, 32'h1);
      chk("p_addr", IMemAddr, 32'hFFFF_FFFC);
      tick();
      IMemGnt = 1'b0; IMemValid = 1'b1; IMemRData = 32'h3333_3333;
      tick();
      IMemValid = 1'b0;
      settle();
      chk("r_pc",   PC, 32'hFFFF_FFFC);
      chk("r_pc8",  PCPlus8, 32'h0000_0004);
      chk("r_addr", IMemAddr, 32'h0);
      chk("r_req",  {31'h0, IMemReq}, 32'h1);
      IMemGnt = 1'b1;
      tick();

      // Reset while WAIT with a response arriving during reset
      IMemGnt = 1'b0; RESET = 1'b1; IMemValid = 1'b1; IMemRData = 32'h4444_4444;
      settle();
      chk("s_ivalid", {31'h0, InstrValid}, 32'h0);
      chk("s_req",    {31'h0, IMemReq}, 32'h0);
      chk("s_pc",     PC, 32'h0);
      tick();
      RESET = 1'b0;
      settle();
      chk("t_ivalid", {31'h0, InstrValid}, 32'h0);
      chk("t_req",    {31'h0, IMemReq}, 32'h1);
      chk("t_addr",   IMemAddr, 32'h0);
      tick();
      IMemValid = 1'b0;
      settle();
      chk("u_ivalid", {31'h0, InstrValid}, 32'h0);

      // Back-to-back redirects: last one wins
      PCSrc = 1'b1; Result = 32'h0000_0080;
      tick();
      Result = 32'h0000_0090;
      tick();
      PCSrc = 1'b0;
      settle();
      chk("v_req",  {31'h0, IMemReq}, 32'h1);
      chk("v_addr", IMemAddr, 32'h90);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
